display_scan: RTL and testbench



---
 rtl/display_scan_pkg.sv | 16 +
 rtl/display_scan_lz_blank.sv | 25 ++
 rtl/display_scan.sv | 116 +++++++++++
 tb/tb_display_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// Shared constants and types for the 7-segment display path.
package display_scan_pkg;

  // Active-low segment pattern, bit6=a ... bit0=g.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_ZERO  = 7'b0000001;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Slot phase: anodes dark during GUARD, one anode lit during ON.
  typedef enum logic {
    SLOT_GUARD = 1'b0,
    SLOT_ON    = 1'b1
  } slot_t;

endpackage

// File: rtl/display_scan_lz_blank.sv
// Leading-zero blank mask: digit i (i>=1) is blanked when blanking is enabled
// and every digit from i up to the most significant one is exactly ZERO.
module lz_blank
  import display_scan_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  seg_t [NDIG-1:0] digits,
  input  logic            blank_lz,
  output logic [NDIG-1:0] blank
);

  logic zero_run;

  // Walk from the most significant digit downward while the run of zeros holds.
  always_comb begin
    zero_run = blank_lz;
    blank    = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run = zero_run && (digits[i] == SEG_ZERO);
      blank[i] = zero_run;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-segment scan driver with double-buffered digit data,
// leading-zero blanking and a dark guard interval at the start of each slot.
//
// state      | meaning
// -----------+---------------------------------------------------------
// SLOT_GUARD | cnt < GUARD: all anodes off, segment bus blank
// SLOT_ON    | cnt >= GUARD: anode idx low, segment bus = disp(idx)
module display_scan
  import display_scan_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [7*NDIG-1:0] dig_in,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NDIG);

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  slot_t           slot_q, slot_d;
  logic            wrap;
  seg_t [NDIG-1:0] dig_v;
  seg_t [NDIG-1:0] pend_q, act_q;
  logic [NDIG-1:0] blank_mask;
  seg_t            seg_d;
  logic [NDIG-1:0] an_d;

  assign dig_v = dig_in;

  lz_blank #(.NDIG(NDIG)) u_lz_blank (
    .digits   (act_q),
    .blank_lz (blank_lz),
    .blank    (blank_mask)
  );

  // Prescaler and digit index advance; wrap marks the last edge of a frame.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    wrap  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Slot FSM next state and the output values that go with it. Outputs are
  // computed from the next cnt/idx so the registered outputs match them.
  // The active buffer only changes when cnt returns to 0 (a GUARD cycle),
  // so reading the current buffer here is equivalent to reading the next one.
  always_comb begin
    slot_d = slot_q;
    seg_d  = SEG_BLANK;
    an_d   = '1;
    case (slot_q)
      SLOT_GUARD: if (cnt_d == CNT_GUARD) slot_d = SLOT_ON;
      SLOT_ON:    if (cnt_d == '0)        slot_d = SLOT_GUARD;
      default:    slot_d = SLOT_GUARD;
    endcase
    if (slot_d == SLOT_ON) begin
      an_d  = ~(NDIG'(1) << idx_d);
      seg_d = blank_mask[idx_d] ? SEG_BLANK : act_q[idx_d];
    end
  end

  // Scan state and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      slot_q     <= SLOT_GUARD;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= wrap;
    end
  end

  // Double buffer: pending follows load; active takes a frame's worth of data
  // only at the wrap, with a coincident load bypassing pending.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend_q <= {NDIG{SEG_ZERO}};
      act_q  <= {NDIG{SEG_ZERO}};
    end else begin
      if (load) pend_q <= dig_v;
      if (wrap) act_q  <= load ? dig_v : pend_q;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan with a frame-level reference model.
module tb_display_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] Z    = 7'b0000001;
  localparam logic [6:0] ONE  = 7'b1001111;
  localparam logic [6:0] FOUR = 7'b1001100;
  localparam logic [6:0] BL   = 7'h7F;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [7*ND-1:0] dig_in = {ND{7'b0000001}};
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int mk    = 0;

  logic [6:0]    m_pend [ND];
  logic [6:0]    m_act  [ND];
  logic [6:0]    e_seg;
  logic [ND-1:0] e_an;
  logic          e_fd;

  display_scan #(.NDIG(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk        (clk),
    .clr        (clr),
    .load       (load),
    .dig_in     (dig_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, mk);
    end
  endtask

  function automatic logic [6:0] digit_of(input logic [7*ND-1:0] v, input int j);
    return v[7*j +: 7];
  endfunction

  // Reference: mk counts edges since reset release; slot position is plain
  // arithmetic on mk, buffers are arrays updated at frame boundaries.
  always @(posedge clk) begin
    if (clr) begin
      mk = 0;
      for (int j = 0; j < ND; j++) begin
        m_pend[j] = Z;
        m_act[j]  = Z;
      end
    end else begin
      int c, d;
      logic all_zero;
      mk++;
      if (mk % FRAME == 0)
        for (int j = 0; j < ND; j++) m_act[j] = load ? digit_of(dig_in, j) : m_pend[j];
      if (load)
        for (int j = 0; j < ND; j++) m_pend[j] = digit_of(dig_in, j);
      c = mk % RD;
      d = (mk / RD) % ND;
      e_fd = (mk % FRAME == 0);
      if (c < GD) begin
        e_an  = '1;
        e_seg = BL;
      end else begin
        e_an = '1;
        e_an[d] = 1'b0;
        all_zero = 1'b1;
        for (int j = d; j < ND; j++) if (m_act[j] != Z) all_zero = 1'b0;
        e_seg = (blank_lz && d >= 1 && all_zero) ? BL : m_act[d];
      end
      #1;
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_frame_done", frame_done, e_fd);
    end
  end

  task automatic to_edge(input int t);
    int n = 0;
    while (mk != t && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (mk != t) begin
      total++;
      bad++;
      $display("FAIL wait_edge: reached %0d expected %0d", mk, t);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    clr = 1'b0;

    // Reset release and first slots
    to_edge(1);
    chk("rst_an_e1", an, 4'b1111);
    chk("rst_seg_e1", seg, BL);
    chk("rst_fd_e1", frame_done, 1'b0);
    to_edge(2);
    chk("an_e2", an, 4'b1110);
    chk("seg_e2", seg, Z);
    to_edge(8);
    chk("an_e8", an, 4'b1111);
    to_edge(10);
    chk("an_e10", an, 4'b1101);

    // Load during frame 0 shows in frame 1
    dig_in = {Z, Z, Z, ONE};
    load = 1'b1;
    to_edge(11);
    load = 1'b0;
    to_edge(32);
    chk("fd_e32", frame_done, 1'b1);
    to_edge(33);
    chk("fd_e33", frame_done, 1'b0);
    to_edge(34);
    chk("seg_load_e34", seg, ONE);
    chk("an_load_e34", an, 4'b1110);

    // Leading-zero blanking
    to_edge(40);
    dig_in = {Z, FOUR, Z, Z};
    load = 1'b1;
    blank_lz = 1'b1;
    to_edge(41);
    load = 1'b0;
    to_edge(82);
    chk("lz_seg_d2", seg, FOUR);
    chk("lz_an_d2", an, 4'b1011);
    to_edge(90);
    chk("lz_seg_d3", seg, BL);
    chk("lz_an_d3", an, 4'b0111);
    to_edge(100);
    dig_in = {ND{Z}};
    load = 1'b1;
    to_edge(101);
    load = 1'b0;
    to_edge(130);
    chk("lz_seg_d0", seg, Z);
    to_edge(138);
    chk("lz_seg_d1", seg, BL);
    chk("lz_an_d1", an, 4'b1101);
    to_edge(139);
    blank_lz = 1'b0;

    // Load coincident with wrap bypasses pending
    to_edge(140);
    dig_in = {Z, Z, Z, ONE};
    load = 1'b1;
    to_edge(141);
    load = 1'b0;
    to_edge(191);
    dig_in = {Z, Z, Z, FOUR};
    load = 1'b1;
    to_edge(192);
    load = 1'b0;
    chk("bypass_fd", frame_done, 1'b1);
    to_edge(194);
    chk("bypass_seg", seg, FOUR);

    // Back-to-back loads: last wins
    to_edge(200);
    dig_in = {Z, Z, Z, ONE};
    load = 1'b1;
    to_edge(201);
    dig_in = {Z, Z, Z, FOUR};
    to_edge(202);
    load = 1'b0;
    to_edge(258);
    chk("b2b_seg", seg, FOUR);

    // Random traffic
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < ND; j++)
        dig_in[7*j +: 7] = ($urandom_range(0, 1) == 1) ? Z : 7'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;

    // Asynchronous reset at idx=2, cnt=5
    to_edge(1653);
    #2 clr = 1'b1;
    #1;
    chk("async_an", an, 4'b1111);
    chk("async_seg", seg, BL);
    chk("async_fd", frame_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    blank_lz = 1'b0;
    to_edge(2);
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_seg", seg, Z);
    to_edge(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
